fcvt_wu_s_unit: RTL and testbench



---
 rtl/fcvt_wu_s_unit.sv | 167 ++++++++++++++++
 tb/tb_fcvt_wu_s_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fcvt_wu_s_unit.sv
// FCVT.WU.S: binary32 to unsigned 32-bit integer, four-state multi-cycle unit.
// One operation in flight; the result is held in DONE until the consumer takes it.
module fcvt_wu_s_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RM_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     fp_in,
  input  logic [RM_W-1:0] rm,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] int_out,
  output logic [4:0]      fflags
);

  typedef enum logic [1:0] {StIdle, StAlign, StRound, StDone} state_e;

  state_e            state_q;
  logic [31:0]       op_q;
  logic [RM_W-1:0]   rm_q;
  logic [XLEN-1:0]   mag_q;
  logic              guard_q, sticky_q, sign_q, nan_q, inf_q, ovf_q;

  // Align: classify the operand and shift the significand to an integer magnitude.
  logic [7:0]      exp_a;
  logic [22:0]     frac_a;
  logic [23:0]     mant_a;
  logic [4:0]      rsh_a;
  logic [23:0]     lost_a;
  logic [XLEN-1:0] mag_a;
  logic            guard_a, sticky_a, nan_a, inf_a, ovf_a;

  always_comb begin
    exp_a    = op_q[30:23];
    frac_a   = op_q[22:0];
    mant_a   = {1'b1, frac_a};
    rsh_a    = 5'd0;
    lost_a   = '0;
    mag_a    = '0;
    guard_a  = 1'b0;
    sticky_a = 1'b0;
    nan_a    = 1'b0;
    inf_a    = 1'b0;
    ovf_a    = 1'b0;
    if (exp_a == 8'hFF) begin
      nan_a = (frac_a != '0);
      inf_a = (frac_a == '0);
    end else if (exp_a == 8'd0) begin
      sticky_a = (frac_a != '0);
    end else if (exp_a >= 8'd159) begin
      ovf_a = 1'b1;
    end else if (exp_a >= 8'd150) begin
      mag_a = XLEN'(mant_a) << (exp_a - 8'd150);
    end else if (exp_a >= 8'd127) begin
      rsh_a    = 5'(8'd150 - exp_a);
      mag_a    = XLEN'(mant_a >> rsh_a);
      lost_a   = mant_a & ((24'd1 << rsh_a) - 24'd1);
      guard_a  = lost_a[rsh_a - 5'd1];
      sticky_a = |(lost_a & ~(24'd1 << (rsh_a - 5'd1)));
    end else if (exp_a == 8'd126) begin
      guard_a  = 1'b1;
      sticky_a = (frac_a != '0);
    end else begin
      // Below 0.5 the hidden bit alone makes the value inexact.
      sticky_a = 1'b1;
    end
  end

  // Round: apply the rounding increment, then range-check the 33-bit sum.
  logic            inexact_r, inc_r;
  logic [XLEN:0]   sum_r;
  logic [XLEN-1:0] res_int;
  logic [4:0]      res_flags;

  always_comb begin
    inexact_r = guard_q | sticky_q;
    unique case (rm_q)
      3'd1:    inc_r = 1'b0;
      3'd2:    inc_r = sign_q & inexact_r;
      3'd3:    inc_r = ~sign_q & inexact_r;
      3'd4:    inc_r = guard_q;
      default: inc_r = guard_q & (sticky_q | mag_q[0]);
    endcase
    sum_r     = {1'b0, mag_q} + {{XLEN{1'b0}}, inc_r};
    res_int   = '0;
    res_flags = 5'b0;
    if (nan_q) begin
      res_int   = '1;
      res_flags = 5'b10000;
    end else if (sign_q) begin
      if (inf_q || ovf_q || (sum_r != '0)) begin
        res_flags = 5'b10000;
      end else begin
        res_flags = {4'b0, inexact_r};
      end
    end else if (inf_q || ovf_q || sum_r[XLEN]) begin
      res_int   = '1;
      res_flags = 5'b10000;
    end else begin
      res_int   = sum_r[XLEN-1:0];
      res_flags = {4'b0, inexact_r};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      int_out   <= '0;
      fflags    <= '0;
      op_q      <= '0;
      rm_q      <= '0;
      mag_q     <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      sign_q    <= 1'b0;
      nan_q     <= 1'b0;
      inf_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (flush && (state_q != StIdle)) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            op_q     <= fp_in;
            rm_q     <= rm;
            in_ready <= 1'b0;
            state_q  <= StAlign;
          end
        end
        StAlign: begin
          mag_q    <= mag_a;
          guard_q  <= guard_a;
          sticky_q <= sticky_a;
          sign_q   <= op_q[31];
          nan_q    <= nan_a;
          inf_q    <= inf_a;
          ovf_q    <= ovf_a;
          state_q  <= StRound;
        end
        StRound: begin
          int_out   <= res_int;
          fflags    <= res_flags;
          out_valid <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fcvt_wu_s_unit.sv
// Directed bench for fcvt_wu_s_unit: expected results queue at issue, checked at delivery.
module tb_fcvt_wu_s_unit;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] fp_in, int_out;
  logic [2:0]  rm;
  logic [4:0]  fflags;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [36:0] exp_q[$];
  string       tag_q[$];
  int          pop_cyc[$];

  fcvt_wu_s_unit #(.XLEN(32), .RM_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_in     (fp_in),
    .rm        (rm),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .int_out   (int_out),
    .fflags    (fflags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every delivered result must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    logic [36:0] e;
    string       t;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {63'b0, out_valid}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, {27'b0, int_out, fflags}, {27'b0, e});
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic send(input logic [31:0] f, input logic [2:0] r, input logic [31:0] ei,
                      input logic [4:0] ef, input string tag);
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      check({tag, "_accept"}, {63'b0, in_ready}, 64'd1);
      return;
    end
    exp_q.push_back({ei, ef});
    tag_q.push_back(tag);
    fp_in    = f;
    rm       = r;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rm       = r ^ 3'b011;  // must not affect the accepted operation
    fp_in    = $urandom;
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; fp_in = '0; rm = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  {63'b0, in_ready}, 64'd1);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_int_out",   {32'b0, int_out}, 64'd0);
    check("rst_fflags",    {59'b0, fflags}, 64'd0);

    send(32'h3FC00000, 3'd0, 32'd2,          5'h01, "p1_5_rne");
    send(32'h3FC00000, 3'd1, 32'd1,          5'h01, "p1_5_rtz");
    send(32'h40200000, 3'd0, 32'd2,          5'h01, "p2_5_rne");
    send(32'h40200000, 3'd4, 32'd3,          5'h01, "p2_5_rmm");
    send(32'h40200000, 3'd3, 32'd3,          5'h01, "p2_5_rup");
    send(32'h40200000, 3'd7, 32'd2,          5'h01, "p2_5_rm7");
    send(32'h40600000, 3'd0, 32'd4,          5'h01, "p3_5_rne");
    send(32'h3FFFFFFF, 3'd0, 32'd2,          5'h01, "p1_99_rne");
    send(32'h3FFFFFFF, 3'd2, 32'd1,          5'h01, "p1_99_rdn");
    send(32'h3F7FFFFF, 3'd0, 32'd1,          5'h01, "p0_99_rne");
    send(32'h4F7FFFFF, 3'd0, 32'hFFFFFF00,   5'h00, "max_exact");
    send(32'h4F7FFFFF, 3'd3, 32'hFFFFFF00,   5'h00, "max_rup");
    send(32'h4F800000, 3'd0, 32'hFFFFFFFF,   5'h10, "two_pow_32");
    send(32'h7F800000, 3'd0, 32'hFFFFFFFF,   5'h10, "pos_inf");
    send(32'h7FC00000, 3'd0, 32'hFFFFFFFF,   5'h10, "qnan");
    send(32'hFF800001, 3'd1, 32'hFFFFFFFF,   5'h10, "neg_nan");
    send(32'hBF000000, 3'd1, 32'd0,          5'h01, "m0_5_rtz");
    send(32'hBF000000, 3'd2, 32'd0,          5'h10, "m0_5_rdn");
    send(32'hBE99999A, 3'd3, 32'd0,          5'h01, "m0_3_rup");
    send(32'hBF800000, 3'd1, 32'd0,          5'h10, "m1_0_rtz");
    send(32'hFF800000, 3'd0, 32'd0,          5'h10, "neg_inf");
    send(32'h80000000, 3'd0, 32'd0,          5'h00, "neg_zero");
    send(32'h00000001, 3'd3, 32'd1,          5'h01, "denorm_rup");
    drain("drain_directed");

    // Latency and backpressure.
    @(negedge clk);
    exp_q.push_back({32'd10, 5'h00});
    tag_q.push_back("lat_10");
    fp_in = 32'h41200000; rm = 3'd0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("lat_edge1", {63'b0, out_valid}, 64'd0);
    @(negedge clk);
    check("lat_edge2", {63'b0, out_valid}, 64'd0);
    @(negedge clk);
    check("lat_edge3", {63'b0, out_valid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      check("bp_valid",    {63'b0, out_valid}, 64'd1);
      check("bp_int_out",  {32'b0, int_out}, 64'd10);
      check("bp_fflags",   {59'b0, fflags}, 64'd0);
      check("bp_in_ready", {63'b0, in_ready}, 64'd0);
      if (i == 2) begin
        fp_in = 32'h3F800000; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_in_ready",  {63'b0, in_ready}, 64'd1);
    check("bp_release_out_valid", {63'b0, out_valid}, 64'd0);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Flush while in ROUND.
    @(negedge clk);
    fp_in = 32'h42280000; rm = 3'd0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("flush_no_valid", {63'b0, out_valid}, 64'd0);
    end
    check("flush_in_ready", {63'b0, in_ready}, 64'd1);
    send(32'h41200000, 3'd0, 32'd10, 5'h00, "post_flush");
    drain("drain_flush");

    // Reset while in ALIGN.
    @(negedge clk);
    fp_in = 32'h3FC00000; rm = 3'd0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst2_int_out",  {32'b0, int_out}, 64'd0);
    check("rst2_fflags",   {59'b0, fflags}, 64'd0);
    check("rst2_in_ready", {63'b0, in_ready}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      check("rst2_no_valid", {63'b0, out_valid}, 64'd0);
      @(negedge clk);
    end
    send(32'h40200000, 3'd4, 32'd3, 5'h01, "post_rst");
    drain("drain_rst");

    // Back-to-back with out_ready high.
    pop_cyc.delete();
    send(32'h41200000, 3'd0, 32'd10, 5'h00, "b2b_0");
    send(32'h3FC00000, 3'd1, 32'd1,  5'h01, "b2b_1");
    send(32'h4F7FFFFF, 3'd0, 32'hFFFFFF00, 5'h00, "b2b_2");
    drain("drain_b2b");
    check("b2b_count", 64'(pop_cyc.size()), 64'd3);
    if (pop_cyc.size() == 3) begin
      check("b2b_gap01", 64'(pop_cyc[1] - pop_cyc[0]), 64'd4);
      check("b2b_gap12", 64'(pop_cyc[2] - pop_cyc[1]), 64'd4);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
